// File: rtl/nav_pkg.sv
// Shared definitions for the menu navigation block: key codes, FSM states
// and small key classification helpers.
package nav_pkg;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_UP    = 3'd1,
        KEY_LEFT  = 3'd2,
        KEY_DOWN  = 3'd3,
        KEY_RIGHT = 3'd4,
        KEY_ENTER = 3'd5
    } key_t;

    typedef enum logic [1:0] {
        LOCK   = 2'd0,
        IDLE   = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } nav_state_t;

    function automatic logic key_is_dir(input logic [2:0] k);
        return (k >= 3'd1) && (k <= 3'd4);
    endfunction

    function automatic logic key_is_valid(input logic [2:0] k);
        return (k >= 3'd1) && (k <= 3'd5);
    endfunction

endpackage

// File: rtl/nav_repeat_timer.sv
// Typematic timer: counts cycles since the last action and flags when the
// first-repeat delay (arm_first=1) or the repeat period (arm_first=0) is up.
module nav_repeat_timer #(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic arm_first,
    output logic fire
);

    localparam int MAXP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = ($clog2(MAXP) < 1) ? 1 : $clog2(MAXP);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

    logic [TW-1:0] r_count;
    logic [TW-1:0] w_last;

    assign w_last = arm_first ? DELAY_LAST : RATE_LAST;
    assign fire   = (r_count == w_last);

    // Stops at the terminal value so a held enter key can never overflow it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (!fire) begin
            r_count <= r_count + TW'(1);
        end
    end

endmodule

// File: rtl/key_nav.sv
// Keyboard-to-menu navigation: registers the key code, generates move/select
// pulses with typematic repeat, and maintains a ROWS x COLS cursor.
module key_nav
    import nav_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int WRAP         = 1,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    key_num,
    input  logic          enable,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          move_pulse,
    output logic          select_pulse,
    output logic [RW-1:0] sel_row,
    output logic [CW-1:0] sel_col
);

    localparam logic [RW:0] ROW_LAST = (RW+1)'(ROWS - 1);
    localparam logic [CW:0] COL_LAST = (CW+1)'(COLS - 1);

    logic [2:0]    r_key_q;
    logic          r_key_vld;
    logic [2:0]    r_cur_key;
    nav_state_t    r_state;
    nav_state_t    w_next;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_sel_row;
    logic [CW-1:0] r_sel_col;
    logic          r_move;
    logic          r_sel;

    logic          w_act;
    logic [2:0]    w_act_key;
    logic          w_clear;
    logic          w_latch;
    logic          w_fire;
    logic          w_arm_first;
    logic [RW:0]   w_row_ext;
    logic [RW:0]   w_row_new;
    logic [CW:0]   w_col_ext;
    logic [CW:0]   w_col_new;
    logic          w_moved;

    // Codes 6 and 7 fold to "no key"; r_key_vld keeps the reset value of
    // r_key_q from looking like a release while a key is held out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_q   <= KEY_NONE;
            r_key_vld <= 1'b0;
        end else begin
            r_key_q   <= (key_num > 3'd5) ? KEY_NONE : key_num;
            r_key_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= LOCK;
            r_cur_key <= KEY_NONE;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_cur_key <= r_key_q;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_act     = 1'b0;
        w_act_key = r_key_q;
        w_clear   = 1'b0;
        w_latch   = 1'b0;
        if (!enable) begin
            w_next  = LOCK;
            w_clear = 1'b1;
        end else begin
            case (r_state)
                LOCK: begin
                    w_clear = 1'b1;
                    if (r_key_vld && (r_key_q == KEY_NONE)) begin
                        w_next = IDLE;
                    end
                end
                IDLE: begin
                    w_clear = 1'b1;
                    if (key_is_valid(r_key_q)) begin
                        w_act   = 1'b1;
                        w_latch = 1'b1;
                        w_next  = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (r_key_q == KEY_NONE) begin
                        w_clear = 1'b1;
                        w_next  = IDLE;
                    end else if (key_is_valid(r_key_q) && (r_key_q != r_cur_key)) begin
                        w_act   = 1'b1;
                        w_latch = 1'b1;
                        w_clear = 1'b1;
                        w_next  = HOLD;
                    end else if (w_fire && key_is_dir(r_cur_key)) begin
                        w_act     = 1'b1;
                        w_act_key = r_cur_key;
                        w_clear   = 1'b1;
                        w_next    = REPEAT;
                    end
                end
                default: begin
                    w_next  = LOCK;
                    w_clear = 1'b1;
                end
            endcase
        end
    end

    assign w_arm_first = (r_state != REPEAT);

    nav_repeat_timer #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .arm_first (w_arm_first),
        .fire      (w_fire)
    );

    // Candidate position one bit wider than the cursor so edges are detected
    // by compare rather than by truncation.
    always_comb begin
        w_row_ext = {1'b0, r_row};
        w_col_ext = {1'b0, r_col};
        w_row_new = w_row_ext;
        w_col_new = w_col_ext;
        case (w_act_key)
            KEY_UP: begin
                if (w_row_ext == '0) begin
                    if (WRAP != 0) w_row_new = ROW_LAST;
                end else begin
                    w_row_new = w_row_ext - (RW+1)'(1);
                end
            end
            KEY_DOWN: begin
                if (w_row_ext >= ROW_LAST) begin
                    if (WRAP != 0) w_row_new = '0;
                end else begin
                    w_row_new = w_row_ext + (RW+1)'(1);
                end
            end
            KEY_LEFT: begin
                if (w_col_ext == '0) begin
                    if (WRAP != 0) w_col_new = COL_LAST;
                end else begin
                    w_col_new = w_col_ext - (CW+1)'(1);
                end
            end
            KEY_RIGHT: begin
                if (w_col_ext >= COL_LAST) begin
                    if (WRAP != 0) w_col_new = '0;
                end else begin
                    w_col_new = w_col_ext + (CW+1)'(1);
                end
            end
            default: begin
                w_row_new = w_row_ext;
                w_col_new = w_col_ext;
            end
        endcase
        w_moved = (w_row_new != w_row_ext) || (w_col_new != w_col_ext);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_sel_row <= '0;
            r_sel_col <= '0;
            r_move    <= 1'b0;
            r_sel     <= 1'b0;
        end else begin
            r_move <= 1'b0;
            r_sel  <= 1'b0;
            if (w_act) begin
                if (w_act_key == KEY_ENTER) begin
                    r_sel     <= 1'b1;
                    r_sel_row <= r_row;
                    r_sel_col <= r_col;
                end else if (w_moved) begin
                    r_move <= 1'b1;
                    r_row  <= w_row_new[RW-1:0];
                    r_col  <= w_col_new[CW-1:0];
                end
            end
        end
    end

    assign row          = r_row;
    assign col          = r_col;
    assign sel_row      = r_sel_row;
    assign sel_col      = r_sel_col;
    assign move_pulse   = r_move;
    assign select_pulse = r_sel;

endmodule

// File: tb/tb_key_nav.sv
// Self-checking bench for key_nav: a wrapping and a saturating instance share
// stimulus and are compared every cycle against a press-age reference model.
module tb_key_nav;

    localparam int ROWS  = 3;
    localparam int COLS  = 4;
    localparam int DELAY = 8;
    localparam int RATE  = 3;
    localparam int RW    = 2;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [2:0]    key_num;
    logic [RW-1:0] dRow    [2];
    logic [CW-1:0] dCol    [2];
    logic [RW-1:0] dSelRow [2];
    logic [CW-1:0] dSelCol [2];
    logic          dMove   [2];
    logic          dSel    [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_nav #(.ROWS(ROWS), .COLS(COLS), .WRAP(1), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) dutW (
        .clk(clk), .rst(rst_n), .key_num(key_num), .enable(enable),
        .row(dRow[0]), .col(dCol[0]), .move_pulse(dMove[0]), .select_pulse(dSel[0]),
        .sel_row(dSelRow[0]), .sel_col(dSelCol[0])
    );

    key_nav #(.ROWS(ROWS), .COLS(COLS), .WRAP(0), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) dutS (
        .clk(clk), .rst(rst_n), .key_num(key_num), .enable(enable),
        .row(dRow[1]), .col(dCol[1]), .move_pulse(dMove[1]), .select_pulse(dSel[1]),
        .sel_row(dSelRow[1]), .sel_col(dSelCol[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Reference model: actions happen on a fresh press (age 0) and, for
    // direction keys, at ages DELAY, DELAY+RATE, DELAY+2*RATE, ...
    int mKq;
    bit mLocked;
    int mPressed;
    int mAge;
    int mRow [2];
    int mCol [2];
    int mSelRow [2];
    int mSelCol [2];
    bit mMove [2];
    bit mSel [2];

    function automatic int stepAxis(input int pos, input int delta, input int size, input bit wrap);
        int p;
        p = pos + delta;
        if (p < 0)     return wrap ? size - 1 : 0;
        if (p >= size) return wrap ? 0 : size - 1;
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mKq = -1;
            mLocked = 1'b1;
            mPressed = 0;
            mAge = 0;
            for (int i = 0; i < 2; i++) begin
                mRow[i] = 0; mCol[i] = 0; mSelRow[i] = 0; mSelCol[i] = 0;
                mMove[i] = 1'b0; mSel[i] = 1'b0;
            end
        end else begin
            int kOld;
            int actKey;
            int r;
            int c;
            kOld = mKq;
            mKq = (key_num > 3'd5) ? 0 : int'(key_num);
            actKey = 0;
            if (!enable) begin
                mLocked = 1'b1;
                mPressed = 0;
            end else if (mLocked) begin
                if (kOld == 0) mLocked = 1'b0;
            end else if (kOld == 0) begin
                mPressed = 0;
            end else if (kOld != mPressed) begin
                actKey = kOld;
                mPressed = kOld;
                mAge = 0;
            end else begin
                mAge++;
                if (mPressed <= 4 && mAge >= DELAY && ((mAge - DELAY) % RATE) == 0) actKey = mPressed;
            end
            for (int i = 0; i < 2; i++) begin
                mMove[i] = 1'b0;
                mSel[i] = 1'b0;
                if (actKey == 5) begin
                    mSel[i] = 1'b1;
                    mSelRow[i] = mRow[i];
                    mSelCol[i] = mCol[i];
                end else if (actKey != 0) begin
                    r = stepAxis(mRow[i], (actKey == 3) ? 1 : (actKey == 1) ? -1 : 0, ROWS, i == 0);
                    c = stepAxis(mCol[i], (actKey == 4) ? 1 : (actKey == 2) ? -1 : 0, COLS, i == 0);
                    if (r != mRow[i] || c != mCol[i]) begin
                        mMove[i] = 1'b1;
                        mRow[i] = r;
                        mCol[i] = c;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("model_row[%0d]", i), dRow[i], mRow[i]);
                checkOutput($sformatf("model_col[%0d]", i), dCol[i], mCol[i]);
                checkOutput($sformatf("model_move[%0d]", i), dMove[i], mMove[i]);
                checkOutput($sformatf("model_select[%0d]", i), dSel[i], mSel[i]);
                checkOutput($sformatf("model_sel_row[%0d]", i), dSelRow[i], mSelRow[i]);
                checkOutput($sformatf("model_sel_col[%0d]", i), dSelCol[i], mSelCol[i]);
                checkOutput($sformatf("pulse_exclusive[%0d]", i), dMove[i] & dSel[i], 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] key, input logic en, input int n);
        key_num = key;
        enable = en;
        repeat (n) tick();
    endtask

    task automatic resetDuts();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(3'd0, 1'b1, 3);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nW;
        bit isRep;
        int cntSel;
        int cntMove;
        logic [RW-1:0] frozenRow;
        logic [CW-1:0] frozenCol;
        int segKey;
        int segLen;

        rst_n = 1'b0;
        key_num = 3'd3;
        enable = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_row", dRow[i], 0);
            checkOutput("reset_move", dMove[i], 0);
        end
        rst_n = 1'b1;

        // Key held through reset release must be ignored until released.
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t1_locked_move", dMove[0], 0);
        end
        applyStimulus(3'd0, 1'b1, 2);
        key_num = 3'd3;
        tick();
        checkOutput("t1_move_early", dMove[0], 0);
        tick();
        checkOutput("t1_move", dMove[0], 1);
        checkOutput("t1_row", dRow[0], 1);
        checkOutput("t1_row_sat", dRow[1], 1);
        applyStimulus(3'd0, 1'b1, 3);

        // Blocked moves at the origin on the saturating instance.
        resetDuts();
        applyStimulus(3'd1, 1'b1, 1);
        key_num = 3'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t3_move_sat", dMove[1], 0);
            checkOutput("t3_row_sat", dRow[1], 0);
            checkOutput("t3_col_sat", dCol[1], 0);
        end
        applyStimulus(3'd0, 1'b1, 3);

        // Typematic timing while holding right.
        resetDuts();
        key_num = 3'd4;
        nW = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            isRep = (k == 2 || k == 10 || k == 13 || k == 16 || k == 19);
            if (isRep) nW++;
            checkOutput($sformatf("t2_move_k%0d", k), dMove[0], isRep);
            checkOutput($sformatf("t2_col_k%0d", k), dCol[0], nW % 4);
            checkOutput($sformatf("t2_move_sat_k%0d", k), dMove[1], isRep && nW <= 3);
            checkOutput($sformatf("t2_col_sat_k%0d", k), dCol[1], (nW > 3) ? 3 : nW);
        end
        applyStimulus(3'd0, 1'b1, 3);

        // Move to (1,2), then hold enter.
        resetDuts();
        applyStimulus(3'd3, 1'b1, 1);
        applyStimulus(3'd0, 1'b1, 2);
        applyStimulus(3'd4, 1'b1, 1);
        applyStimulus(3'd0, 1'b1, 2);
        applyStimulus(3'd4, 1'b1, 1);
        applyStimulus(3'd0, 1'b1, 2);
        checkOutput("t4_row", dRow[0], 1);
        checkOutput("t4_col", dCol[0], 2);
        key_num = 3'd5;
        cntSel = 0;
        cntMove = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            cntSel += int'(dSel[0]);
            cntMove += int'(dMove[0]);
        end
        checkOutput("t4_select_count", cntSel, 1);
        checkOutput("t4_move_count", cntMove, 0);
        checkOutput("t4_sel_row", dSelRow[0], 1);
        checkOutput("t4_sel_col", dSelCol[0], 2);
        applyStimulus(3'd0, 1'b1, 3);

        // Switch from a repeating down key straight to right.
        applyStimulus(3'd3, 1'b1, 10);
        checkOutput("t5_first_repeat", dMove[0], 1);
        checkOutput("t5_row_wrapped", dRow[0], 0);
        key_num = 3'd4;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checkOutput($sformatf("t5_move_k%0d", k), dMove[0], (k == 2 || k == 10));
            if (k == 2)  checkOutput("t5_col_after_switch", dCol[0], 3);
            if (k == 10) checkOutput("t5_col_after_delay", dCol[0], 0);
        end
        tick();
        checkOutput("t6_repeat_before_disable", dMove[0], 1);

        // Disable during REPEAT, re-enable with the key still held.
        enable = 1'b0;
        frozenRow = dRow[0];
        frozenCol = dCol[0];
        for (int k = 0; k < 18; k++) begin
            if (k == 6) enable = 1'b1;
            tick();
            checkOutput("t6_no_move", dMove[0], 0);
            checkOutput("t6_no_select", dSel[0], 0);
            checkOutput("t6_row_frozen", dRow[0], frozenRow);
            checkOutput("t6_col_frozen", dCol[0], frozenCol);
        end
        applyStimulus(3'd0, 1'b1, 3);
        key_num = 3'd3;
        tick();
        tick();
        checkOutput("t6_after_release", dMove[0], 1);
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("t6_async_row", dRow[i], 0);
            checkOutput("t6_async_col", dCol[i], 0);
            checkOutput("t6_async_sel_row", dSelRow[i], 0);
            checkOutput("t6_async_sel_col", dSelCol[i], 0);
            checkOutput("t6_async_move", dMove[i], 0);
            checkOutput("t6_async_select", dSel[i], 0);
        end
        tick();
        rst_n = 1'b1;
        applyStimulus(3'd0, 1'b1, 3);

        // Randomized segments of held keys, enable drops and occasional resets.
        for (int s = 0; s < 300; s++) begin
            segKey = $urandom_range(0, 7);
            segLen = $urandom_range(1, 20);
            applyStimulus(3'(segKey), ($urandom_range(0, 9) != 0), segLen);
            if ($urandom_range(0, 49) == 0) begin
                #3;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        applyStimulus(3'd0, 1'b1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
